// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between inst_mem and decode
//
// Owns the fetch PC and buffers up to DEPTH {pc, inst} pairs so fetch keeps
// running while decode is stalled. A redirect flushes everything and restarts
// fetch at the target.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   imem_addr/data     fetch PC out, combinational instruction back
//   redirect_valid/pc  taken branch/jump from execute (highest priority)
//   deq_ready          decode accepts the head entry
//   deq_valid/pc/inst  head entry (pc=0, inst=NOP_INST when empty)
//   count/full/empty   occupancy
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_inst,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] entry_pc_q   [DEPTH];
    logic [XLEN-1:0] entry_inst_q [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] fpc_q, fpc_d;

    logic enq;
    logic deq;

    assign imem_addr = fpc_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign deq_valid = !empty;

    // Head outputs come from registers only; empty shows a harmless NOP.
    assign deq_pc    = empty ? '0       : entry_pc_q[head_q];
    assign deq_inst  = empty ? NOP_INST : entry_inst_q[head_q];

    assign deq = deq_valid & deq_ready;
    // A full queue may still accept when the head leaves in the same cycle.
    assign enq = !redirect_valid & (!full | deq);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fpc_d   = fpc_q;
        if (redirect_valid) begin
            // Flush wins over everything, including a same-cycle dequeue.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fpc_d   = redirect_pc;
        end else begin
            if (enq) begin
                tail_d = tail_q + PW'(1);
                fpc_d  = fpc_q + XLEN'(4);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fpc_q   <= RESET_PC;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fpc_q   <= fpc_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_pc_q[tail_q]   <= fpc_q;
            entry_inst_q[tail_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq_ready = 1'b0;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int failures = 0;

    // Reference model: a plain queue of fetched PCs plus the fetch PC.
    logic [31:0] mq[$];
    logic [31:0] mfpc;

    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ SALT;

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_pc(deq_pc), .deq_inst(deq_inst),
        .count(count), .full(full), .empty(empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mfpc = 32'h0;
    endtask

    task automatic model_update();
        bit d;
        bit e;
        d = (mq.size() > 0) && deq_ready;
        if (redirect_valid) begin
            mq.delete();
            mfpc = redirect_pc;
        end else begin
            e = (mq.size() < 4) || d;
            if (d) void'(mq.pop_front());
            if (e) begin
                mq.push_back(mfpc);
                mfpc = mfpc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        check({tag, ".count"},     32'(count),     32'(n));
        check({tag, ".deq_valid"}, 32'(deq_valid), 32'(n != 0));
        check({tag, ".full"},      32'(full),      32'(n == 4));
        check({tag, ".empty"},     32'(empty),     32'(n == 0));
        check({tag, ".imem_addr"}, imem_addr,      mfpc);
        check({tag, ".deq_pc"},    deq_pc,         (n != 0) ? mq[0] : 32'h0);
        check({tag, ".deq_inst"},  deq_inst,       (n != 0) ? (mq[0] ^ SALT) : NOP);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".deq_valid"}, 32'(deq_valid), 32'd0);
        check({tag, ".empty"},     32'(empty),     32'd1);
        check({tag, ".full"},      32'(full),      32'd0);
        check({tag, ".count"},     32'(count),     32'd0);
        check({tag, ".deq_pc"},    deq_pc,         32'h0);
        check({tag, ".deq_inst"},  deq_inst,       NOP);
        check({tag, ".imem_addr"}, imem_addr,      32'h0);
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        int          ecount;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Expected state after the edge on which each row's inputs are applied.
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1, 32'h0,   32'h4};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   2, 32'h0,   32'h8};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   3, 32'h0,   32'hC};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   4, 32'h0,   32'h10};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   4, 32'h0,   32'h10};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   4, 32'h0,   32'h10};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   4, 32'h4,   32'h14};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   4, 32'h4,   32'h14};
        tbl[8]  = '{1'b1, 1'b1, 32'h200, 0, 32'h0,   32'h200};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   1, 32'h200, 32'h204};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1, 32'h204, 32'h208};
        tbl[11] = '{1'b0, 1'b1, 32'h102, 0, 32'h0,   32'h102};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1, 32'h102, 32'h106};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Directed table
        foreach (tbl[i]) begin
            logic [31:0] einst;
            deq_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            tick();
            einst = (tbl[i].ecount == 0) ? NOP : (tbl[i].epc ^ SALT);
            check($sformatf("tbl%0d.count", i),     32'(count),     32'(tbl[i].ecount));
            check($sformatf("tbl%0d.full", i),      32'(full),      32'(tbl[i].ecount == 4));
            check($sformatf("tbl%0d.deq_valid", i), 32'(deq_valid), 32'(tbl[i].ecount != 0));
            check($sformatf("tbl%0d.deq_pc", i),    deq_pc,         tbl[i].epc);
            check($sformatf("tbl%0d.deq_inst", i),  deq_inst,       einst);
            check($sformatf("tbl%0d.imem_addr", i), imem_addr,      tbl[i].eaddr);
        end
        redirect_valid = 1'b0;

        // Randomised run against the model (covers many pointer wraps)
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 600; c++) begin
            deq_ready      = ($urandom_range(0, 99) < 55);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = $urandom();
            tick();
            check_model($sformatf("rnd%0d", c));
        end
        redirect_valid = 1'b0;

        // Redirect with 3 entries queued while decode is ready
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        deq_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("redir3.count_before", 32'(count), 32'd3);
        deq_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("redir3.count",     32'(count),     32'd0);
        check("redir3.deq_valid", 32'(deq_valid), 32'd0);
        check("redir3.deq_inst",  deq_inst,       NOP);
        check("redir3.imem_addr", imem_addr,      32'h200);
        tick();
        check("redir3.deq_pc",    deq_pc,         32'h200);
        check_model("redir3");

        // Async reset mid-fill
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        deq_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("areset.count_before", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("areset");
        @(negedge clk);
        rst = 1'b1;
        deq_ready = 1'b1;
        tick();
        check("areset.first_valid", 32'(deq_valid), 32'd1);
        check("areset.first_pc",    deq_pc,         32'h0);
        tick();
        check_model("areset.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue replacing the single-entry IF/ID register between `inst_mem` and decode. It owns the fetch PC, requests one instruction per cycle from the combinational instruction memory, and buffers up to `DEPTH` {PC, instruction} pairs. This lets fetch continue while decode is stalled by the hazard unit. A branch/jump redirect from execute flushes all buffered entries and restarts fetch at the target.

## Interface
- `XLEN`, 32: PC and instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `NOP_INST`, 32'h0000_0013: value driven on `deq_inst` when empty (addi x0,x0,0).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `imem_addr` out XLEN: current fetch PC, to `inst_mem`.
- `imem_data` in XLEN: instruction at `imem_addr`, same cycle (combinational memory).
- `redirect_valid` in 1: taken branch/jump resolved in execute.
- `redirect_pc` in XLEN: redirect target.
- `deq_ready` in 1: decode accepts head entry (low = hazard stall).
- `deq_valid` out 1: head entry valid.
- `deq_pc` out XLEN: head entry PC.
- `deq_inst` out XLEN: head entry instruction.
- `count` out $clog2(DEPTH+1): occupied entries.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.

## Operation
- Storage: DEPTH-entry circular buffer, head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus occupancy counter. Fetch PC register `fpc`, with `imem_addr = fpc`.
- deq = `deq_valid & deq_ready`.
- enq = `!redirect_valid & (!full | deq)`. Writes {fpc, imem_data} at tail, advances tail, sets `fpc <= fpc + 4` (modulo 2^XLEN).
- Full with simultaneous deq: enqueue and dequeue both happen and `count` is unchanged.
- Empty: no bypass. A newly fetched entry is visible at the head the following cycle.
- `count_next = count + enq - deq` in all non-redirect cycles. `count` never exceeds DEPTH and never underflows.
- Redirect (priority over everything):
  - head, tail, and count go to 0.
  - `fpc <= redirect_pc`.
  - No enqueue that cycle.
  - The head entry is discarded even if `deq_ready` is high. Decode must treat that cycle's head as squashed; execute flushes ID/EX in the same cycle.
- `redirect_pc` is not alignment-checked. Bits [1:0] pass through unchanged.
- Head outputs:
  - `deq_valid = !empty`.
  - `deq_pc`/`deq_inst` = entry at head when non-empty.
  - When empty: `deq_pc = 0`, `deq_inst = NOP_INST`.
- No states beyond pointers/counter/fpc; queue behaviour is fully defined by `count`: EMPTY (0), PARTIAL, FULL (DEPTH).

## Timing
- Reset (async assert, sync-to-clk deassert by the system):
  - `fpc = RESET_PC`; head = tail = count = 0.
  - Outputs: `deq_valid = 0`, `empty = 1`, `full = 0`, `deq_pc = 0`, `deq_inst = NOP_INST`, `imem_addr = RESET_PC`.
- Reset asserted mid-operation: all entries discarded immediately, outputs take reset values without waiting for a clock edge.
- Fetch-to-decode latency: 1 cycle. The instruction at `imem_addr` in cycle N is at the head in cycle N+1 if the queue was empty.
- Redirect latency:
  - Redirect in cycle N → `imem_addr = redirect_pc` in N+1.
  - The target instruction is at the head in N+2.
  - `deq_valid = 0` in N+1.
- Stall: with `deq_ready = 0` from an empty start, the queue fills in DEPTH cycles. `fpc` then holds until space frees.
- Throughput: one instruction per cycle sustained when `deq_ready = 1`.
- All outputs except `imem_addr` derive from registers only. No combinational path from `deq_ready`, `redirect_*` or `imem_data` to any output.

## Test plan
- Reset then run, DEPTH=4, `deq_ready = 1`, imem returns `addr^32'hA5A5_0000`:
  - `deq_valid` rises in cycle 1.
  - `deq_pc` = 0, 4, 8, … on consecutive cycles; `count` stays 1.
- Stall fill: `deq_ready = 0` for 6 cycles.
  - `count` goes 1,2,3,4,4,4 and `full = 1` from cycle 4.
  - `imem_addr` holds at 0x10.
  - On release, PCs 0,4,8,C then 0x10 emerge back-to-back.
- Full with simultaneous deq: keep `full` and pulse `deq_ready` for 1 cycle.
  - `count` stays 4.
  - The entry with PC 0x10 enters and the head advances to PC 4.
- Redirect with 3 entries queued and `deq_ready = 1`, `redirect_pc = 0x200`:
  - Next cycle: `count = 0`, `deq_valid = 0`, `deq_inst = 0x13`, `imem_addr = 0x200`.
  - The following cycle: `deq_pc = 0x200`.
- Pointer wrap: stream 3·DEPTH+1 instructions while toggling `deq_ready` pseudo-randomly.
  - The PC sequence at the deq side is strictly +4 with no loss or duplication.
- Async reset mid-fill (`count = 3`): assert `rst` low between edges.
  - Outputs reach reset values before the next edge.
  - After deassert, the first `deq_pc` is `RESET_PC`.
